// File: rtl/ex_stage.sv
// Execute stage: ID/EX register (s1), operand forwarding into the external
// combinational ALU, and the EX/MEM register (s2) toward the memory stage.
// Valid/ready handshakes give back-pressure in both directions.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [3:0]  id_opcode,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic        id_use_imm,
    input  logic        id_wb_en,
    input  logic        flush,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_q,
    input  logic        mem_fwd_en,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_result,
    output logic [4:0]  ex_rd,
    output logic        ex_wb_en
);

    // s1 (ID/EX) state
    logic        s1_valid_q, s1_valid_d;
    logic [3:0]  s1_opcode_q, s1_opcode_d;
    logic [4:0]  s1_rs1_q, s1_rs1_d;
    logic [4:0]  s1_rs2_q, s1_rs2_d;
    logic [4:0]  s1_rd_q, s1_rd_d;
    logic [31:0] s1_op1_q, s1_op1_d;
    logic [31:0] s1_op2_q, s1_op2_d;
    logic [31:0] s1_imm_q, s1_imm_d;
    logic        s1_use_imm_q, s1_use_imm_d;
    logic        s1_wb_en_q, s1_wb_en_d;

    // s2 (EX/MEM) state
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_result_q, s2_result_d;
    logic [4:0]  s2_rd_q, s2_rd_d;
    logic        s2_wb_en_q, s2_wb_en_d;

    logic        s2_adv;
    logic        s1_adv;
    logic [31:0] rs2_fwd;

    // Forward the youngest producer of rs; x0 always reads the stored value.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  rs,
        input logic [31:0] stored,
        input logic        s2_hit_en,
        input logic [4:0]  s2_rd,
        input logic [31:0] s2_val,
        input logic        m_en,
        input logic [4:0]  m_rd,
        input logic [31:0] m_val,
        input logic        w_en,
        input logic [4:0]  w_rd,
        input logic [31:0] w_val
    );
        if (rs == 5'd0)                return stored;
        if (s2_hit_en && s2_rd == rs)  return s2_val;
        if (m_en && m_rd == rs)        return m_val;
        if (w_en && w_rd == rs)        return w_val;
        return stored;
    endfunction

    // Next stored operand: bypass WB at capture time, or snoop WB while held,
    // so a value written during a stall is not lost once WB moves on.
    function automatic logic [31:0] op_next(
        input logic        adv,
        input logic        held_valid,
        input logic [4:0]  id_rs,
        input logic [31:0] id_data,
        input logic [4:0]  q_rs,
        input logic [31:0] q_op,
        input logic        w_en,
        input logic [4:0]  w_rd,
        input logic [31:0] w_val
    );
        if (adv)
            return (w_en && w_rd == id_rs && id_rs != 5'd0) ? w_val : id_data;
        if (held_valid && w_en && w_rd == q_rs && q_rs != 5'd0)
            return w_val;
        return q_op;
    endfunction

    assign s2_adv   = !s2_valid_q || ex_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign id_ready = s1_adv;

    // Operand selection toward the ALU
    always_comb begin
        alu_a   = fwd_sel(s1_rs1_q, s1_op1_q, s2_valid_q && s2_wb_en_q, s2_rd_q, s2_result_q,
                          mem_fwd_en, mem_rd, mem_data, wb_en, wb_rd, wb_data);
        rs2_fwd = fwd_sel(s1_rs2_q, s1_op2_q, s2_valid_q && s2_wb_en_q, s2_rd_q, s2_result_q,
                          mem_fwd_en, mem_rd, mem_data, wb_en, wb_rd, wb_data);
        alu_b   = s1_use_imm_q ? s1_imm_q : rs2_fwd;
        alu_op  = s1_opcode_q;
    end

    // Next-state for both pipeline registers
    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_rd_d      = s2_rd_q;
        s2_wb_en_d   = s2_wb_en_q;
        s1_valid_d   = s1_valid_q;
        s1_opcode_d  = s1_opcode_q;
        s1_rs1_d     = s1_rs1_q;
        s1_rs2_d     = s1_rs2_q;
        s1_rd_d      = s1_rd_q;
        s1_imm_d     = s1_imm_q;
        s1_use_imm_d = s1_use_imm_q;
        s1_wb_en_d   = s1_wb_en_q;

        if (s2_adv) begin
            // flush kills the s1 instruction on its way into s2
            s2_valid_d  = s1_valid_q && !flush;
            s2_result_d = alu_q;
            s2_rd_d     = s1_rd_q;
            s2_wb_en_d  = s1_wb_en_q;
        end

        if (s1_adv) begin
            s1_valid_d   = id_valid && !flush;
            s1_opcode_d  = id_opcode;
            s1_rs1_d     = id_rs1;
            s1_rs2_d     = id_rs2;
            s1_rd_d      = id_rd;
            s1_imm_d     = id_imm;
            s1_use_imm_d = id_use_imm;
            s1_wb_en_d   = id_wb_en;
        end else if (flush) begin
            s1_valid_d = 1'b0;
        end

        s1_op1_d = op_next(s1_adv, s1_valid_q, id_rs1, id_rs1_data, s1_rs1_q, s1_op1_q,
                           wb_en, wb_rd, wb_data);
        s1_op2_d = op_next(s1_adv, s1_valid_q, id_rs2, id_rs2_data, s1_rs2_q, s1_op2_q,
                           wb_en, wb_rd, wb_data);
    end

    // Pipeline registers; reset drops any in-flight instruction immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_opcode_q  <= 4'd0;
            s1_rs1_q     <= 5'd0;
            s1_rs2_q     <= 5'd0;
            s1_rd_q      <= 5'd0;
            s1_op1_q     <= 32'd0;
            s1_op2_q     <= 32'd0;
            s1_imm_q     <= 32'd0;
            s1_use_imm_q <= 1'b0;
            s1_wb_en_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= 32'd0;
            s2_rd_q      <= 5'd0;
            s2_wb_en_q   <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_opcode_q  <= s1_opcode_d;
            s1_rs1_q     <= s1_rs1_d;
            s1_rs2_q     <= s1_rs2_d;
            s1_rd_q      <= s1_rd_d;
            s1_op1_q     <= s1_op1_d;
            s1_op2_q     <= s1_op2_d;
            s1_imm_q     <= s1_imm_d;
            s1_use_imm_q <= s1_use_imm_d;
            s1_wb_en_q   <= s1_wb_en_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_rd_q      <= s2_rd_d;
            s2_wb_en_q   <= s2_wb_en_d;
        end
    end

    assign ex_valid  = s2_valid_q;
    assign ex_result = s2_result_q;
    assign ex_rd     = s2_rd_q;
    assign ex_wb_en  = s2_wb_en_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: a small ALU model closes the loop on alu_q; a vector
// table covers independent operations, hand sequences cover the pipeline
// corner cases (forwarding, stalls, flush, asynchronous reset).
module tb_ex_stage;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [3:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm, id_wb_en, flush;
    logic [31:0] alu_a, alu_b, alu_q;
    logic [3:0]  alu_op;
    logic        mem_fwd_en;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready, ex_wb_en;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_q = alu_a + alu_b;
            OP_SUB:  alu_q = alu_a - alu_b;
            OP_AND:  alu_q = alu_a & alu_b;
            OP_OR:   alu_q = alu_a | alu_b;
            OP_XOR:  alu_q = alu_a ^ alu_b;
            default: alu_q = 32'd0;
        endcase
    end

    ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_wb_en(id_wb_en), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_q(alu_q),
        .mem_fwd_en(mem_fwd_en), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_rd(ex_rd), .ex_wb_en(ex_wb_en)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        use_imm;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic ui, input logic we);
        id_valid    = 1'b1;
        id_opcode   = op;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_imm      = imm;
        id_use_imm  = ui;
        id_wb_en    = we;
    endtask

    task automatic idle_id();
        id_valid = 1'b0;
        id_wb_en = 1'b0;
    endtask

    task automatic idle_fwd();
        mem_fwd_en = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    endtask

    initial begin
        vecs[0] = '{OP_ADD, 5'd1,  5'd2,  5'd10, 32'd5,      32'd7,      32'd0,          1'b0, 32'd12};
        vecs[1] = '{OP_SUB, 5'd3,  5'd4,  5'd11, 32'd50,     32'd8,      32'd0,          1'b0, 32'd42};
        vecs[2] = '{OP_AND, 5'd5,  5'd6,  5'd12, 32'hF0F0,   32'hFF00,   32'd0,          1'b0, 32'hF000};
        vecs[3] = '{OP_OR,  5'd7,  5'd8,  5'd13, 32'hF0F0,   32'h0F0F,   32'd0,          1'b0, 32'hFFFF};
        vecs[4] = '{OP_XOR, 5'd9,  5'd10, 5'd14, 32'hFF,     32'h0F,     32'd0,          1'b0, 32'hF0};
        vecs[5] = '{OP_ADD, 5'd11, 5'd0,  5'd15, 32'd10,     32'h1234,   32'hFFFFFFFF,   1'b1, 32'd9};
        vecs[6] = '{OP_SUB, 5'd12, 5'd0,  5'd16, 32'd0,      32'd0,      32'd1,          1'b1, 32'hFFFFFFFF};

        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        drive(OP_ADD, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        idle_id();
        idle_fwd();

        // Reset state
        #1;
        check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset ex_result", ex_result, 32'd0);
        check("reset ex_rd", {27'd0, ex_rd}, 32'd0);
        check("reset ex_wb_en", {31'd0, ex_wb_en}, 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        check("reset alu_op", {28'd0, alu_op}, 32'd0);
        check("reset id_ready", {31'd0, id_ready}, 32'd1);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Independent operations, one per cycle
        for (int i = 0; i <= NV; i++) begin
            if (i < NV)
                drive(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1,
                      vecs[i].d2, vecs[i].imm, vecs[i].use_imm, 1'b0);
            else
                idle_id();
            tick();
            if (i < NV) check($sformatf("vec%0d alu_a", i), alu_a, vecs[i].d1);
            if (i > 0) begin
                check($sformatf("vec%0d ex_valid", i - 1), {31'd0, ex_valid}, 32'd1);
                check($sformatf("vec%0d ex_result", i - 1), ex_result, vecs[i - 1].exp);
                check($sformatf("vec%0d ex_rd", i - 1), {27'd0, ex_rd}, {27'd0, vecs[i - 1].rd});
            end
        end
        tick();
        check("table drain ex_valid", {31'd0, ex_valid}, 32'd0);

        // Dependent ADDs: x1 = 5 + 7, x2 = x1 + 3
        drive(OP_ADD, 5'd1, 5'd2, 5'd1, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1);
        tick();
        drive(OP_ADD, 5'd1, 5'd0, 5'd2, 32'd0, 32'd0, 32'd3, 1'b1, 1'b1);
        tick();
        idle_id();
        check("dep s2 fwd alu_a", alu_a, 32'd12);
        check("dep ex_result1", ex_result, 32'd12);
        tick();
        check("dep ex_result2", ex_result, 32'd15);
        check("dep ex_rd2", {27'd0, ex_rd}, 32'd2);
        check("dep ex_wb_en2", {31'd0, ex_wb_en}, 32'd1);
        tick();
        check("dep drain ex_valid", {31'd0, ex_valid}, 32'd0);

        // Back-pressure with WB snoop into held SUB x4 - x8
        drive(OP_ADD, 5'd5, 5'd6, 5'd7, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
        tick();
        drive(OP_SUB, 5'd4, 5'd8, 5'd9, 32'd50, 32'd1, 32'd0, 1'b0, 1'b1);
        ex_ready = 1'b0;
        tick();
        idle_id();
        check("bp ex_result start", ex_result, 32'd3);
        check("bp id_ready low", {31'd0, id_ready}, 32'd0);
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'd100;
        tick();
        idle_fwd();
        #1;
        check("bp snooped alu_a", alu_a, 32'd100);
        check("bp stall1 ex_result", ex_result, 32'd3);
        tick();
        check("bp stall2 ex_result", ex_result, 32'd3);
        check("bp stall2 ex_valid", {31'd0, ex_valid}, 32'd1);
        tick();
        check("bp stall3 ex_result", ex_result, 32'd3);
        ex_ready = 1'b1;
        drive(OP_XOR, 5'd11, 5'd12, 5'd13, 32'hF, 32'h3, 32'd0, 1'b0, 1'b0);
        #1;
        check("bp release id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        idle_id();
        check("bp release ex_result", ex_result, 32'd99);
        check("bp release ex_rd", {27'd0, ex_rd}, 32'd9);
        tick();
        check("bp next ex_result", ex_result, 32'hC);
        tick();

        // Forwarding priority on x3
        drive(OP_ADD, 5'd20, 5'd21, 5'd3, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);
        tick();
        drive(OP_ADD, 5'd3, 5'd0, 5'd22, 32'h55, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        idle_id();
        mem_fwd_en = 1'b1; mem_rd = 5'd3; mem_data = 32'd8;
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'd9;
        #1;
        check("prio s2 over mem/wb", alu_a, 32'd7);
        idle_fwd();
        tick(); tick();
        drive(OP_ADD, 5'd3, 5'd0, 5'd22, 32'h55, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        idle_id();
        mem_fwd_en = 1'b1; mem_rd = 5'd3; mem_data = 32'd8;
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'd9;
        #1;
        check("prio mem over wb", alu_a, 32'd8);
        mem_fwd_en = 1'b0;
        #1;
        check("prio wb only", alu_a, 32'd9);
        wb_en = 1'b0;
        #1;
        check("prio stored", alu_a, 32'h55);
        idle_fwd();
        tick(); tick();

        // x0 writes never forward
        drive(OP_ADD, 5'd20, 5'd21, 5'd0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);
        tick();
        drive(OP_ADD, 5'd0, 5'd0, 5'd23, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        idle_id();
        mem_fwd_en = 1'b1; mem_rd = 5'd0; mem_data = 32'h66;
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h77;
        #1;
        check("x0 alu_a", alu_a, 32'd0);
        check("x0 alu_b", alu_b, 32'd0);
        idle_fwd();
        tick(); tick();

        // Flush with s1 valid and an incoming instruction
        drive(OP_ADD, 5'd1, 5'd2, 5'd24, 32'h10, 32'h20, 32'd0, 1'b0, 1'b0);
        tick();
        drive(OP_ADD, 5'd1, 5'd2, 5'd25, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
        ex_ready = 1'b0;
        tick();
        drive(OP_ADD, 5'd1, 5'd2, 5'd26, 32'd4, 32'd4, 32'd0, 1'b0, 1'b0);
        flush = 1'b1; ex_ready = 1'b1;
        #1;
        check("flush older ex_valid", {31'd0, ex_valid}, 32'd1);
        check("flush older ex_result", ex_result, 32'h30);
        tick();
        flush = 1'b0;
        idle_id();
        check("flush ex_valid1", {31'd0, ex_valid}, 32'd0);
        tick();
        check("flush ex_valid2", {31'd0, ex_valid}, 32'd0);

        // Asynchronous reset with s1 and s2 valid
        drive(OP_ADD, 5'd1, 5'd2, 5'd27, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1);
        tick();
        drive(OP_ADD, 5'd1, 5'd2, 5'd28, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);
        ex_ready = 1'b0;
        tick();
        idle_id();
        check("pre-rst ex_valid", {31'd0, ex_valid}, 32'd1);
        check("pre-rst id_ready", {31'd0, id_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async rst ex_valid", {31'd0, ex_valid}, 32'd0);
        check("async rst ex_result", ex_result, 32'd0);
        check("async rst id_ready", {31'd0, id_ready}, 32'd1);
        #1 rst = 1'b0;
        ex_ready = 1'b1;
        tick();
        check("post-rst ex_valid", {31'd0, ex_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
